// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB bus arbiter.
package ahb_arb_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  // Index of the set bit in a one-hot vector. Vectors up to 32 masters are supported.
  function automatic int unsigned onehot2idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after i_start, wrapping.
module arb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_grant,
  output logic          o_found
);

  always_comb begin
    int idx;
    idx     = 0;
    o_grant = '0;
    o_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(i_start) + k) % N;
      if (!o_found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_param_arbiter.sv
// Parametrised AHB arbiter: fixed-priority or round-robin, locked transfers, bounded burst hold.
// Arbitration happens only on hready edges; grant, owner index and lock are registered together.
module ahb_param_arbiter import ahb_arb_pkg::*; #(
  parameter int        NUM_MASTERS = 4,
  parameter arb_mode_e ARB_MODE    = ARB_FIXED,
  parameter int        MAX_HOLD    = 4,
  parameter int        MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock,
  output logic                   grant_valid
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_master;
  logic                   r_lock;
  logic [HW-1:0]          r_holdCnt;
  logic [MW-1:0]          r_rrPtr;

  logic                   w_ownerValid;
  logic                   w_ownerReq;
  logic                   w_ownerLock;
  logic                   w_others;
  logic                   w_holdOk;
  logic                   w_retain;
  logic [NUM_MASTERS-1:0] w_cand;
  logic [NUM_MASTERS-1:0] w_pickReq;
  logic [NUM_MASTERS-1:0] w_pickGrant;
  logic [NUM_MASTERS-1:0] w_win;
  logic [MW-1:0]          w_pickStart;
  logic [MW-1:0]          w_winIdx;
  logic                   w_found;

  assign w_ownerValid = |r_grant;
  assign w_ownerReq   = |(hreq & r_grant);
  assign w_ownerLock  = |(hlock & r_grant);
  assign w_others     = |(hreq & ~r_grant);
  assign w_holdOk     = (MAX_HOLD == 0) || (r_holdCnt < HOLD_MAX);
  assign w_retain     = w_ownerValid & w_ownerReq & (w_ownerLock | ~w_others | w_holdOk);

  // An owner still requesting but not retained is being forced off, so it cannot win again.
  assign w_cand = (w_ownerValid & w_ownerReq) ? (hreq & ~r_grant) : hreq;

  assign w_pickStart = (ARB_MODE == ARB_FIXED) ? '0 :
                       (r_rrPtr == MW'(NUM_MASTERS - 1)) ? '0 : r_rrPtr + 1'b1;

  // Fixed priority reuses the rotating picker on a bit-reversed vector so the top index wins.
  always_comb begin
    w_pickReq = '0;
    w_win     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_pickReq[i] = (ARB_MODE == ARB_FIXED) ? w_cand[NUM_MASTERS-1-i] : w_cand[i];
      w_win[i]     = (ARB_MODE == ARB_FIXED) ? w_pickGrant[NUM_MASTERS-1-i] : w_pickGrant[i];
    end
  end

  arb_rr_picker #(.N(NUM_MASTERS), .IW(MW)) u_picker (
    .i_req   (w_pickReq),
    .i_start (w_pickStart),
    .o_grant (w_pickGrant),
    .o_found (w_found)
  );

  assign w_winIdx = MW'(onehot2idx(32'(w_win)));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_grant   <= '0;
      r_master  <= '0;
      r_lock    <= 1'b0;
      r_holdCnt <= '0;
      r_rrPtr   <= MW'(NUM_MASTERS - 1);
    end else if (hready) begin
      if (hreq == '0) begin
        r_grant   <= '0;
        r_master  <= '0;
        r_lock    <= 1'b0;
        r_holdCnt <= '0;
      end else if (w_retain) begin
        r_lock <= w_ownerLock;
        if (!w_ownerLock && w_others && (r_holdCnt != HOLD_MAX))
          r_holdCnt <= r_holdCnt + 1'b1;
      end else if (w_found) begin
        r_grant   <= w_win;
        r_master  <= w_winIdx;
        r_lock    <= |(w_win & hlock);
        r_holdCnt <= '0;
        r_rrPtr   <= w_winIdx;
      end
    end
  end

  assign hgrant      = r_grant;
  assign hmaster     = r_master;
  assign hmastlock   = r_lock;
  assign grant_valid = |r_grant;

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with the same stimulus and
// compares both against an integer-level model of the arbitration rules.
module tb_ahb_param_arbiter;
  import ahb_arb_pkg::*;

  localparam int NM = 4;
  localparam int MH = 2;

  logic          clock;
  logic          reset;
  logic [NM-1:0] hreq;
  logic [NM-1:0] hlock;
  logic          hready;

  logic [NM-1:0] grantF, grantR;
  logic [1:0]    masterF, masterR;
  logic          lockF, lockR;
  logic          validF, validR;

  int checks;
  int errors;

  // Model state per instance: index 0 is fixed priority, index 1 is round robin.
  int mOwner[2];
  int mHold[2];
  int mPtr[2];
  bit mLock[2];

  logic [NM-1:0] rrSeq [9];

  ahb_param_arbiter #(.NUM_MASTERS(NM), .ARB_MODE(ARB_FIXED), .MAX_HOLD(MH)) dutFixed (
    .hclk(clock), .hreset(reset), .hreq(hreq), .hlock(hlock), .hready(hready),
    .hgrant(grantF), .hmaster(masterF), .hmastlock(lockF), .grant_valid(validF)
  );

  ahb_param_arbiter #(.NUM_MASTERS(NM), .ARB_MODE(ARB_RR), .MAX_HOLD(MH)) dutRr (
    .hclk(clock), .hreset(reset), .hreq(hreq), .hlock(hlock), .hready(hready),
    .hgrant(grantR), .hmaster(masterR), .hmastlock(lockR), .grant_valid(validR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mOwner[m] = -1;
      mHold[m]  = 0;
      mPtr[m]   = NM - 1;
      mLock[m]  = 1'b0;
    end
  endtask

  // One hready edge of the arbitration rules for instance m.
  task automatic modelStep(input int m, input logic [NM-1:0] req, input logic [NM-1:0] lck, input logic rdy);
    int own;
    int excl;
    int win;
    bit others;
    if (!rdy) return;
    if (req == '0) begin
      mOwner[m] = -1;
      mHold[m]  = 0;
      mLock[m]  = 1'b0;
      return;
    end
    own = mOwner[m];
    others = 1'b0;
    for (int j = 0; j < NM; j++)
      if (req[j] && j != own) others = 1'b1;
    if (own >= 0 && req[own] && (lck[own] || !others || mHold[m] < MH - 1)) begin
      mLock[m] = lck[own];
      if (!lck[own] && others && mHold[m] < MH - 1) mHold[m]++;
      return;
    end
    excl = (own >= 0 && req[own]) ? own : -1;
    win = -1;
    if (m == 0) begin
      for (int j = NM - 1; j >= 0; j--)
        if (win < 0 && req[j] && j != excl) win = j;
    end else begin
      for (int k = 1; k <= NM; k++) begin
        int j;
        j = (mPtr[m] + k) % NM;
        if (win < 0 && req[j] && j != excl) win = j;
      end
    end
    mOwner[m] = win;
    mHold[m]  = 0;
    mPtr[m]   = win;
    mLock[m]  = lck[win];
  endtask

  task automatic compareModel(input string tag);
    logic [NM-1:0] expGrant;
    int expMaster;
    for (int m = 0; m < 2; m++) begin
      expGrant  = (mOwner[m] >= 0) ? NM'(1 << mOwner[m]) : '0;
      expMaster = (mOwner[m] >= 0) ? mOwner[m] : 0;
      if (m == 0) begin
        checkOutput({tag, " fixed hgrant"}, 32'(grantF), 32'(expGrant));
        checkOutput({tag, " fixed hmaster"}, 32'(masterF), 32'(expMaster));
        checkOutput({tag, " fixed hmastlock"}, 32'(lockF), 32'(mLock[m]));
        checkOutput({tag, " fixed grant_valid"}, 32'(validF), 32'(mOwner[m] >= 0));
      end else begin
        checkOutput({tag, " rr hgrant"}, 32'(grantR), 32'(expGrant));
        checkOutput({tag, " rr hmaster"}, 32'(masterR), 32'(expMaster));
        checkOutput({tag, " rr hmastlock"}, 32'(lockR), 32'(mLock[m]));
        checkOutput({tag, " rr grant_valid"}, 32'(validR), 32'(mOwner[m] >= 0));
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input string tag, input logic [NM-1:0] req, input logic [NM-1:0] lck, input logic rdy);
    @(negedge clock);
    hreq   = req;
    hlock  = lck;
    hready = rdy;
    @(posedge clock);
    modelStep(0, req, lck, rdy);
    modelStep(1, req, lck, rdy);
    #1;
    compareModel(tag);
  endtask

  // Reset is asserted between edges to show it acts without waiting for the clock.
  task automatic applyReset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    hreq  = '0;
    hlock = '0;
    #1;
    checkOutput("reset fixed hgrant", 32'(grantF), 32'h0);
    checkOutput("reset fixed hmaster", 32'(masterF), 32'h0);
    checkOutput("reset fixed hmastlock", 32'(lockF), 32'h0);
    checkOutput("reset rr hgrant", 32'(grantR), 32'h0);
    checkOutput("reset rr hmaster", 32'(masterR), 32'h0);
    checkOutput("reset rr hmastlock", 32'(lockR), 32'h0);
    checkOutput("reset rr grant_valid", 32'(validR), 32'h0);
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    hreq   = '0;
    hlock  = '0;
    hready = 1'b1;
    modelReset();
    rrSeq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    repeat (2) @(negedge clock);
    reset = 1'b0;

    applyStimulus("idle", 4'b0000, 4'b0000, 1'b1);
    checkOutput("idle hgrant", 32'(grantF), 32'h0);

    applyStimulus("fixed 1010", 4'b1010, 4'b0000, 1'b1);
    checkOutput("fixed 1010 grant", 32'(grantF), 32'b1000);
    checkOutput("fixed 1010 master", 32'(masterF), 32'd3);
    applyStimulus("fixed 0110", 4'b0110, 4'b0000, 1'b1);
    checkOutput("fixed 0110 grant", 32'(grantF), 32'b0100);
    checkOutput("fixed 0110 master", 32'(masterF), 32'd2);

    applyReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus("rr fair", 4'b1111, 4'b0000, 1'b1);
      checkOutput($sformatf("rr fair step %0d", i), 32'(grantR), 32'(rrSeq[i]));
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus("lock", 4'b0011, 4'b0001, 1'b1);
      checkOutput("lock grant", 32'(grantR), 32'b0001);
      checkOutput("lock hmastlock", 32'(lockR), 32'd1);
    end
    applyStimulus("unlock", 4'b0011, 4'b0000, 1'b1);
    applyStimulus("unlock", 4'b0011, 4'b0000, 1'b1);
    checkOutput("unlock handoff", 32'(grantR), 32'b0010);

    applyStimulus("stall", 4'b1000, 4'b0000, 1'b0);
    checkOutput("stall hold", 32'(grantR), 32'b0010);
    applyStimulus("stall release", 4'b1000, 4'b0000, 1'b1);
    checkOutput("stall release", 32'(grantR), 32'b1000);

    applyStimulus("seamless a", 4'b0100, 4'b0000, 1'b1);
    checkOutput("seamless owner2", 32'(grantR), 32'b0100);
    applyStimulus("seamless b", 4'b0001, 4'b0000, 1'b1);
    checkOutput("seamless owner0", 32'(grantR), 32'b0001);

    for (int i = 0; i < 400; i++) begin
      logic [NM-1:0] req;
      logic [NM-1:0] lck;
      req = NM'($urandom_range(0, 15));
      lck = '0;
      for (int j = 0; j < NM; j++)
        lck[j] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) applyReset();
      applyStimulus("random", req, lck, $urandom_range(0, 4) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
